// File: rtl/shelter_request_queue_if.sv
// Request/head bus between a shelter (or food) request queue and its neighbours.
interface shelter_request_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          Req_Valid;
    logic [1:0]    Req_Priority;
    logic [7:0]    Req_Zone;
    logic          Req_Ready;
    logic          Serve;
    logic          Out_Valid;
    logic          Out_Boost;
    logic [1:0]    Out_Priority;
    logic [7:0]    Out_Zone;
    logic [CW-1:0] Count;
    logic [7:0]    Drop_Count;

    // Requester/selector side
    modport master (
        output Req_Valid, Req_Priority, Req_Zone, Serve,
        input  Req_Ready, Out_Valid, Out_Boost, Out_Priority, Out_Zone, Count, Drop_Count
    );

    // Queue side
    modport slave (
        input  Req_Valid, Req_Priority, Req_Zone, Serve,
        output Req_Ready, Out_Valid, Out_Boost, Out_Priority, Out_Zone, Count, Drop_Count
    );
endinterface

// File: rtl/shelter_request_queue.sv
// In-order request FIFO presenting its head as a selector candidate, with head
// aging so a long-waiting request raises Out_Boost.
module shelter_request_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AGE_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shelter_request_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = $clog2(AGE_LIMIT + 1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_age;
    logic [7:0]    r_drop_count;
    logic [1:0]    r_mem_pri  [DEPTH];
    logic [7:0]    r_mem_zone [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Ready depends on registered occupancy only, so a full queue never accepts,
    // even when the head is popped in the same cycle.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.Req_Valid & ~w_full;
    assign w_drop  = bus.Req_Valid & w_full;
    assign w_pop   = bus.Serve & ~w_empty;

    // Pointers, occupancy, head age and drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_age        <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A fresh head (after a pop, or into an empty queue) starts at age 0
            if (w_pop || w_empty) begin
                r_age <= '0;
            end else if (r_age != AW'(AGE_LIMIT)) begin
                r_age <= r_age + AW'(1);
            end

            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // Entry storage; contents are left unreset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pri[r_wr_ptr]  <= bus.Req_Priority;
            r_mem_zone[r_wr_ptr] <= bus.Req_Zone;
        end
    end

    assign bus.Req_Ready    = ~w_full;
    assign bus.Out_Valid    = ~w_empty;
    assign bus.Out_Boost    = ~w_empty & (r_age == AW'(AGE_LIMIT));
    assign bus.Out_Priority = r_mem_pri[r_rd_ptr];
    assign bus.Out_Zone     = r_mem_zone[r_rd_ptr];
    assign bus.Count        = r_count;
    assign bus.Drop_Count   = r_drop_count;
endmodule

// File: tb/tb_shelter_request_queue.sv
// Directed bench for shelter_request_queue (DEPTH=8, AGE_LIMIT=15).
module tb_shelter_request_queue;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned AGE_LIMIT = 15;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    shelter_request_queue_if #(.DEPTH(DEPTH)) bus ();

    shelter_request_queue #(.DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; inputs drop back to idle 1ns after the edge
    task automatic cyc(input logic v, input logic [1:0] p, input logic [7:0] z, input logic s);
        bus.Req_Valid    = v;
        bus.Req_Priority = p;
        bus.Req_Zone     = z;
        bus.Serve        = s;
        @(posedge clk);
        #1;
        bus.Req_Valid = 1'b0;
        bus.Serve     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        rst_n = 1'b1;
        n_checks++; if (bus.Count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.Count); end
        n_checks++; if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.Out_Valid); end
        n_checks++; if (bus.Out_Boost !== 1'b0) begin n_fail++; $display("FAIL reset_boost got=%b exp=0", bus.Out_Boost); end
        n_checks++; if (bus.Req_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.Req_Ready); end
        n_checks++; if (bus.Drop_Count !== 8'd0) begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", bus.Drop_Count); end
    endtask

    task automatic test_push_pop();
        cyc(1'b1, 2'd2, 8'h11, 1'b0);
        n_checks++; if (bus.Out_Valid !== 1'b1) begin n_fail++; $display("FAIL pp_first_visible got=%b exp=1", bus.Out_Valid); end
        cyc(1'b1, 2'd1, 8'h22, 1'b0);
        n_checks++; if (bus.Count !== 4'd2) begin n_fail++; $display("FAIL pp_count2 got=%0d exp=2", bus.Count); end
        n_checks++; if (bus.Out_Zone !== 8'h11) begin n_fail++; $display("FAIL pp_head_zone got=%h exp=11", bus.Out_Zone); end
        n_checks++; if (bus.Out_Priority !== 2'd2) begin n_fail++; $display("FAIL pp_head_pri got=%0d exp=2", bus.Out_Priority); end
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        n_checks++; if (bus.Out_Zone !== 8'h22) begin n_fail++; $display("FAIL pp_pop_zone got=%h exp=22", bus.Out_Zone); end
        n_checks++; if (bus.Out_Priority !== 2'd1) begin n_fail++; $display("FAIL pp_pop_pri got=%0d exp=1", bus.Out_Priority); end
        n_checks++; if (bus.Count !== 4'd1) begin n_fail++; $display("FAIL pp_count1 got=%0d exp=1", bus.Count); end
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        n_checks++; if (bus.Count !== 4'd0) begin n_fail++; $display("FAIL pp_drain got=%0d exp=0", bus.Count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (bus.Req_Ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d got=%b exp=1", i, bus.Req_Ready); end
            cyc(1'b1, 2'(i), 8'(8'h30 + i), 1'b0);
        end
        n_checks++; if (bus.Req_Ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", bus.Req_Ready); end
        n_checks++; if (bus.Count !== 4'd8) begin n_fail++; $display("FAIL full_count got=%0d exp=8", bus.Count); end
        cyc(1'b1, 2'd3, 8'hEE, 1'b1);
        n_checks++; if (bus.Drop_Count !== 8'd1) begin n_fail++; $display("FAIL full_drop got=%0d exp=1", bus.Drop_Count); end
        n_checks++; if (bus.Count !== 4'd7) begin n_fail++; $display("FAIL full_count7 got=%0d exp=7", bus.Count); end
        for (int i = 1; i < 8; i++) begin
            n_checks++; if (bus.Out_Zone !== 8'(8'h30 + i)) begin n_fail++; $display("FAIL full_order_%0d got=%h exp=%h", i, bus.Out_Zone, 8'(8'h30 + i)); end
            cyc(1'b0, 2'd0, 8'h00, 1'b1);
        end
        n_checks++; if (bus.Count !== 4'd0) begin n_fail++; $display("FAIL full_drain got=%0d exp=0", bus.Count); end
    endtask

    task automatic test_boost();
        cyc(1'b1, 2'd0, 8'h55, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            cyc(1'b0, 2'd0, 8'h00, 1'b0);
            n_checks++;
            if (bus.Out_Boost !== (k >= AGE_LIMIT)) begin
                n_fail++; $display("FAIL boost_age_%0d got=%b exp=%b", k, bus.Out_Boost, (k >= AGE_LIMIT));
            end
        end
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        n_checks++; if (bus.Out_Boost !== 1'b0) begin n_fail++; $display("FAIL boost_clear got=%b exp=0", bus.Out_Boost); end
        n_checks++; if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL boost_empty got=%b exp=0", bus.Out_Valid); end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 2'd1, 8'h66, 1'b0);
        cyc(1'b1, 2'd3, 8'h77, 1'b1);
        n_checks++; if (bus.Count !== 4'd1) begin n_fail++; $display("FAIL b2b_count got=%0d exp=1", bus.Count); end
        n_checks++; if (bus.Out_Zone !== 8'h77) begin n_fail++; $display("FAIL b2b_zone got=%h exp=77", bus.Out_Zone); end
        n_checks++; if (bus.Out_Priority !== 2'd3) begin n_fail++; $display("FAIL b2b_pri got=%0d exp=3", bus.Out_Priority); end
        // New head must start at age 0: boost appears after exactly AGE_LIMIT idle cycles
        for (int k = 1; k <= AGE_LIMIT; k++) begin
            cyc(1'b0, 2'd0, 8'h00, 1'b0);
            if (k >= AGE_LIMIT - 1) begin
                n_checks++;
                if (bus.Out_Boost !== (k == AGE_LIMIT)) begin
                    n_fail++; $display("FAIL b2b_age_%0d got=%b exp=%b", k, bus.Out_Boost, (k == AGE_LIMIT));
                end
            end
        end
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        n_checks++; if (bus.Count !== 4'd0) begin n_fail++; $display("FAIL b2b_drain got=%0d exp=0", bus.Count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd2, 8'(8'h80 + i), 1'b0);
        n_checks++; if (bus.Count !== 4'd5) begin n_fail++; $display("FAIL rmid_fill got=%0d exp=5", bus.Count); end
        n_checks++; if (bus.Drop_Count !== 8'd1) begin n_fail++; $display("FAIL rmid_drop_pre got=%0d exp=1", bus.Drop_Count); end
        rst_n = 1'b0;
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        rst_n = 1'b1;
        n_checks++; if (bus.Count !== 4'd0) begin n_fail++; $display("FAIL rmid_count got=%0d exp=0", bus.Count); end
        n_checks++; if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", bus.Out_Valid); end
        n_checks++; if (bus.Drop_Count !== 8'd0) begin n_fail++; $display("FAIL rmid_drop got=%0d exp=0", bus.Drop_Count); end
        n_checks++; if (bus.Req_Ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%b exp=1", bus.Req_Ready); end
        cyc(1'b1, 2'd1, 8'h99, 1'b0);
        n_checks++; if (bus.Out_Zone !== 8'h99) begin n_fail++; $display("FAIL rmid_newhead got=%h exp=99", bus.Out_Zone); end
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
    endtask

    task automatic test_wrap();
        int e;
        e = 0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 8'(i), 1'b0);
        for (int i = 3; i < 20; i++) begin
            n_checks++; if (bus.Out_Zone !== 8'(e)) begin n_fail++; $display("FAIL wrap_zone_%0d got=%0d exp=%0d", e, bus.Out_Zone, e); end
            e++;
            cyc(1'b1, 2'd0, 8'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.Out_Zone !== 8'(e)) begin n_fail++; $display("FAIL wrap_zone_%0d got=%0d exp=%0d", e, bus.Out_Zone, e); end
            e++;
            cyc(1'b0, 2'd0, 8'h00, 1'b1);
        end
        n_checks++; if (bus.Count !== 4'd0) begin n_fail++; $display("FAIL wrap_count got=%0d exp=0", bus.Count); end
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        n_checks++; if (bus.Count !== 4'd0) begin n_fail++; $display("FAIL empty_serve_count got=%0d exp=0", bus.Count); end
        n_checks++; if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL empty_serve_valid got=%b exp=0", bus.Out_Valid); end
        n_checks++; if (bus.Drop_Count !== 8'd0) begin n_fail++; $display("FAIL wrap_drop got=%0d exp=0", bus.Drop_Count); end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.Req_Valid    = 1'b0;
        bus.Req_Priority = 2'd0;
        bus.Req_Zone     = 8'h00;
        bus.Serve        = 1'b0;
        test_reset();
        test_push_pop();
        test_full();
        test_boost();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
